// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, byte-class boundaries and
// state encodings for the serial receiver and the message parser.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF     = 4'h8;
   localparam logic [3:0] NOTE_ON      = 4'h9;
   localparam logic [3:0] PROG_CHG     = 4'hC;
   localparam logic [3:0] CHAN_PRESS   = 4'hD;
   localparam logic [7:0] REALTIME_MIN = 8'hF8;
   localparam logic [7:0] SYSTEM_MIN   = 8'hF0;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      P_WAIT_STATUS,
      P_WAIT_D1,
      P_WAIT_D2
   } parse_state_t;

   // Program change and channel pressure carry a single data byte.
   function automatic logic one_data_byte(input logic [7:0] status);
      return (status[7:4] == PROG_CHG) || (status[7:4] == CHAN_PRESS);
   endfunction

endpackage

// File: rtl/midi_uart_byte_rx.sv
// 8N1 serial byte receiver: 2-FF synchroniser, mid-bit sampling FSM,
// registered byte/valid/framing-error outputs plus an early good-byte strobe.
module midi_uart_byte_rx
   import midi_pkg::*;
#(
   parameter int unsigned BIT_CYC = 1600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_framing_err,
   output logic       o_done,
   output logic [7:0] o_shift
);

   localparam int unsigned HALF_CYC = BIT_CYC / 2;
   localparam int unsigned CW       = $clog2(BIT_CYC);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

   rx_state_t      r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic [2:0]     r_bit, w_bit_nxt;
   logic [7:0]     r_shift, w_shift_nxt;
   logic           r_sync1, r_sync2;
   logic           r_byte_valid, r_framing_err;
   logic [7:0]     r_byte;
   logic           w_rx, w_good, w_bad;

   assign w_rx = r_sync2;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_cnt_nxt = '0;
            if (!w_rx) w_state_nxt = RX_START;
         end
         RX_START: begin
            if (r_cnt == HALF_LAST) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {w_rx, r_shift[7:1]};
               w_bit_nxt   = r_bit + 1'b1;
               if (r_bit == 3'd7) w_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (r_cnt == BIT_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = RX_IDLE;
               w_good      = w_rx;
               w_bad       = !w_rx;
            end
         end
         default: w_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_state       <= RX_IDLE;
         r_cnt         <= '0;
         r_bit         <= '0;
         r_shift       <= '0;
         r_byte        <= '0;
         r_byte_valid  <= 1'b0;
         r_framing_err <= 1'b0;
      end else begin
         r_sync1       <= i_rx;
         r_sync2       <= r_sync1;
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_bit         <= w_bit_nxt;
         r_shift       <= w_shift_nxt;
         r_byte_valid  <= w_good;
         r_framing_err <= w_bad;
         if (w_good) r_byte <= r_shift;
      end
   end

   assign o_byte        = r_byte;
   assign o_byte_valid  = r_byte_valid;
   assign o_framing_err = r_framing_err;
   assign o_done        = w_good;
   assign o_shift       = r_shift;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI input front end: serial byte receiver plus a running-status
// channel-voice parser emitting note-on / note-off pulses.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned BAUD    = 31250,
   parameter int unsigned CHANNEL = 0,
   parameter int unsigned OMNI    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       midi_in,
   output logic [7:0] midi_data,
   output logic       midi_valid,
   output logic       note_off,
   output logic [6:0] velocity,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       framing_err
);

   localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
   localparam logic [3:0]  CHAN4   = 4'(CHANNEL);

   logic       w_done;
   logic [7:0] w_byte;

   midi_uart_byte_rx #(.BIT_CYC(BIT_CYC)) u_byte_rx (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_rx          (midi_in),
      .o_byte        (byte_data),
      .o_byte_valid  (byte_valid),
      .o_framing_err (framing_err),
      .o_done        (w_done),
      .o_shift       (w_byte)
   );

   parse_state_t r_pstate, w_pstate_nxt;
   logic [7:0]   r_status, w_status_nxt;
   logic [6:0]   r_d1, w_d1_nxt;
   logic         w_complete, w_chan_ok, w_on, w_off;
   logic [7:0]   r_midi_data;
   logic [6:0]   r_velocity;
   logic         r_midi_valid, r_note_off;

   // Parser advances on the receiver's stop-bit strobe so its registered
   // pulses line up with byte_valid.
   always_comb begin
      w_pstate_nxt = r_pstate;
      w_status_nxt = r_status;
      w_d1_nxt     = r_d1;
      w_complete   = 1'b0;
      if (w_done) begin
         if (w_byte >= REALTIME_MIN) begin
            w_pstate_nxt = r_pstate;
         end else if (w_byte >= SYSTEM_MIN) begin
            w_pstate_nxt = P_WAIT_STATUS;
            w_status_nxt = '0;
         end else if (w_byte[7]) begin
            w_pstate_nxt = P_WAIT_D1;
            w_status_nxt = w_byte;
         end else begin
            case (r_pstate)
               P_WAIT_D1: begin
                  w_d1_nxt = w_byte[6:0];
                  if (!one_data_byte(r_status)) w_pstate_nxt = P_WAIT_D2;
               end
               P_WAIT_D2: begin
                  w_complete   = 1'b1;
                  w_pstate_nxt = P_WAIT_D1;
               end
               default: w_pstate_nxt = P_WAIT_STATUS;
            endcase
         end
      end
   end

   assign w_chan_ok = (OMNI != 0) || (r_status[3:0] == CHAN4);
   assign w_on  = w_complete && w_chan_ok && (r_status[7:4] == NOTE_ON) && (w_byte[6:0] != '0);
   assign w_off = w_complete && w_chan_ok &&
                  ((r_status[7:4] == NOTE_OFF) ||
                   ((r_status[7:4] == NOTE_ON) && (w_byte[6:0] == '0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pstate     <= P_WAIT_STATUS;
         r_status     <= '0;
         r_d1         <= '0;
         r_midi_data  <= '0;
         r_velocity   <= '0;
         r_midi_valid <= 1'b0;
         r_note_off   <= 1'b0;
      end else begin
         r_pstate     <= w_pstate_nxt;
         r_status     <= w_status_nxt;
         r_d1         <= w_d1_nxt;
         r_midi_valid <= w_on;
         r_note_off   <= w_off;
         if (w_on || w_off) begin
            r_midi_data <= {1'b0, r_d1};
            r_velocity  <= w_byte[6:0];
         end
      end
   end

   assign midi_data  = r_midi_data;
   assign velocity   = r_velocity;
   assign midi_valid = r_midi_valid;
   assign note_off   = r_note_off;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx: omni instance and a channel-2 instance
// share one serial line; bit period shortened to 16 clocks.
module tb_midi_uart_rx;

   localparam int unsigned CLK_HZ = 500_000;
   localparam int unsigned BAUD   = 31250;
   localparam int unsigned BITC   = CLK_HZ / BAUD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       midi_in = 1'b1;
   logic [7:0] a_md, a_bd, b_md, b_bd;
   logic [6:0] a_vel, b_vel;
   logic       a_mv, a_no, a_bv, a_fe, b_mv, b_no, b_bv, b_fe;

   always #10 clk = ~clk;

   midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0), .OMNI(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .midi_in(midi_in),
      .midi_data(a_md), .midi_valid(a_mv), .note_off(a_no), .velocity(a_vel),
      .byte_data(a_bd), .byte_valid(a_bv), .framing_err(a_fe)
   );

   midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(2), .OMNI(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .midi_in(midi_in),
      .midi_data(b_md), .midi_valid(b_mv), .note_off(b_no), .velocity(b_vel),
      .byte_data(b_bd), .byte_valid(b_bv), .framing_err(b_fe)
   );

   int         n_assert = 0;
   int         n_fail = 0;
   int         n_bv = 0, n_fe = 0, n_both = 0, n_lat = 0, n_b_bv = 0;
   logic [7:0] bv_log[$];
   logic [15:0] ev_log[$];
   logic [15:0] ev_b[$];

   // Event capture away from the active edge.
   always @(negedge clk) begin
      if (a_bv) begin n_bv++; bv_log.push_back(a_bd); end
      if (b_bv) n_b_bv++;
      if (a_fe) n_fe++;
      if (a_mv && a_no) n_both++;
      if ((a_mv || a_no) && !a_bv) n_lat++;
      if (a_mv || a_no) ev_log.push_back({a_no, a_md, a_vel});
      if (b_mv || b_no) ev_b.push_back({b_no, b_md, b_vel});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop_ok, input int idle);
      midi_in = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         midi_in = b[i];
         repeat (BITC) @(negedge clk);
      end
      if (stop_ok) begin
         midi_in = 1'b1;
         repeat (BITC) @(negedge clk);
      end else begin
         midi_in = 1'b0;
         repeat (12) @(negedge clk);
         midi_in = 1'b1;
         repeat (BITC - 12) @(negedge clk);
      end
      repeat (idle) @(negedge clk);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_md",  a_md,  8'h00);
      chk("rst_mv",  a_mv,  1'b0);
      chk("rst_no",  a_no,  1'b0);
      chk("rst_vel", a_vel, 7'h00);
      chk("rst_bd",  a_bd,  8'h00);
      chk("rst_bv",  a_bv,  1'b0);
      chk("rst_fe",  a_fe,  1'b0);

      // Reset asserted part-way through a frame.
      midi_in = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      midi_in = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("abort_bv", n_bv, 0);
      chk("abort_fe", n_fe, 0);
      chk("abort_bd", a_bd, 8'h00);

      // 1: single note-on
      send(8'h90, 1'b1, 4); send(8'h3C, 1'b1, 4); send(8'h64, 1'b1, 20);
      chk("t1_bvcnt", n_bv, 3);
      chk("t1_b0", bv_log[0], 8'h90);
      chk("t1_b1", bv_log[1], 8'h3C);
      chk("t1_b2", bv_log[2], 8'h64);
      chk("t1_evcnt", ev_log.size(), 1);
      chk("t1_ev0", ev_log[0], {1'b0, 8'h3C, 7'h64});

      // 2: running status, vel 0 is note-off
      send(8'h90, 1'b1, 4); send(8'h3C, 1'b1, 4); send(8'h64, 1'b1, 4);
      send(8'h3E, 1'b1, 4); send(8'h50, 1'b1, 4);
      send(8'h3E, 1'b1, 4); send(8'h00, 1'b1, 20);
      chk("t2_bvcnt", n_bv, 10);
      chk("t2_evcnt", ev_log.size(), 4);
      chk("t2_ev1", ev_log[1], {1'b0, 8'h3C, 7'h64});
      chk("t2_ev2", ev_log[2], {1'b0, 8'h3E, 7'h50});
      chk("t2_ev3", ev_log[3], {1'b1, 8'h3E, 7'h00});
      chk("t2_hold_md", a_md, 8'h3E);
      chk("t2_hold_vel", a_vel, 7'h00);

      // 3: real-time byte inside a message
      send(8'h90, 1'b1, 4); send(8'h3C, 1'b1, 4);
      send(8'hF8, 1'b1, 4); send(8'h64, 1'b1, 20);
      chk("t3_bvcnt", n_bv, 14);
      chk("t3_f8", bv_log[12], 8'hF8);
      chk("t3_evcnt", ev_log.size(), 5);
      chk("t3_ev4", ev_log[4], {1'b0, 8'h3C, 7'h64});

      // 4: system byte clears status, framed-bad status is discarded
      send(8'hF0, 1'b1, 4);
      send(8'h90, 1'b0, 40);
      chk("t4_fe", n_fe, 1);
      chk("t4_bvcnt", n_bv, 15);
      send(8'h3C, 1'b1, 4); send(8'h64, 1'b1, 20);
      chk("t4_bvcnt2", n_bv, 17);
      chk("t4_evcnt", ev_log.size(), 5);

      // 5: short glitch then a normal message
      midi_in = 1'b0;
      repeat (3) @(negedge clk);
      midi_in = 1'b1;
      repeat (60) @(negedge clk);
      chk("t5_bvcnt", n_bv, 17);
      chk("t5_fe", n_fe, 1);
      send(8'h90, 1'b1, 4); send(8'h3C, 1'b1, 4); send(8'h64, 1'b1, 20);
      chk("t5_evcnt", ev_log.size(), 6);
      chk("t5_ev5", ev_log[5], {1'b0, 8'h3C, 7'h64});

      // Status in WAIT_D2 drops the partial message
      send(8'h90, 1'b1, 4); send(8'h3D, 1'b1, 4);
      send(8'h90, 1'b1, 4); send(8'h3E, 1'b1, 4); send(8'h20, 1'b1, 20);
      chk("d2_evcnt", ev_log.size(), 7);
      chk("d2_ev6", ev_log[6], {1'b0, 8'h3E, 7'h20});

      // Explicit note-off status
      send(8'h80, 1'b1, 4); send(8'h3E, 1'b1, 4); send(8'h40, 1'b1, 20);
      chk("off_evcnt", ev_log.size(), 8);
      chk("off_ev7", ev_log[7], {1'b1, 8'h3E, 7'h40});
      chk("chb_none", ev_b.size(), 0);

      // 6: channel filter on instance B
      send(8'h91, 1'b1, 4); send(8'h40, 1'b1, 4); send(8'h7F, 1'b1, 20);
      chk("t6_ch1_a", ev_log.size(), 9);
      chk("t6_ch1_b", ev_b.size(), 0);
      send(8'h92, 1'b1, 4); send(8'h40, 1'b1, 4); send(8'h7F, 1'b1, 20);
      chk("t6_ch2_cnt", ev_b.size(), 1);
      chk("t6_ch2_ev", ev_b[0], {1'b0, 8'h40, 7'h7F});
      send(8'hC2, 1'b1, 4); send(8'h05, 1'b1, 4);
      send(8'h92, 1'b1, 4); send(8'h41, 1'b1, 4); send(8'h10, 1'b1, 20);
      chk("t6_pc_cnt", ev_b.size(), 2);
      chk("t6_pc_ev", ev_b[1], {1'b0, 8'h41, 7'h10});
      chk("t6_b_bvcnt", n_b_bv, n_bv);

      chk("excl", n_both, 0);
      chk("latency", n_lat, 0);
      chk("fe_total", n_fe, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
